// File: rtl/result_drain.sv
// Snapshots the N x N accumulator outputs of the systolic array in one cycle.
// It then streams the elements out in row-major order over a valid/ready interface.
module result_drain #(
    parameter int unsigned N          = 4,
    parameter int unsigned DATA_WIDTH = 8,
    localparam int unsigned IW        = (N > 1) ? $clog2(N) : 1,
    localparam int unsigned EW        = 2 * DATA_WIDTH
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              capture_i,
    input  logic [N*N*EW-1:0] c_i,
    output logic              busy_o,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [EW-1:0]     out_data_o,
    output logic [IW-1:0]     out_row_o,
    output logic [IW-1:0]     out_col_o,
    output logic              out_last_o,
    output logic              overrun_o
);

    localparam int unsigned AW   = (N * N > 1) ? $clog2(N * N) : 1;
    localparam logic [IW-1:0] MAX_IDX = IW'(N - 1);

    typedef enum logic {StIdle, StStream} state_e;

    state_e          state_q, state_d;
    logic [IW-1:0]   row_q, row_d;
    logic [IW-1:0]   col_q, col_d;
    logic            overrun_q, overrun_d;
    logic            load;
    logic            at_last;
    logic [AW-1:0]   idx;
    logic [EW-1:0]   buf_q [N*N];

    assign at_last = (row_q == MAX_IDX) && (col_q == MAX_IDX);
    assign idx     = AW'(row_q) * AW'(N) + AW'(col_q);

    always_comb begin
        state_d   = state_q;
        row_d     = row_q;
        col_d     = col_q;
        overrun_d = overrun_q;
        load      = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (capture_i) begin
                    load    = 1'b1;
                    row_d   = '0;
                    col_d   = '0;
                    state_d = StStream;
                end
            end
            StStream: begin
                if (out_ready_i) begin
                    if (at_last) begin
                        row_d = '0;
                        col_d = '0;
                        // A capture coinciding with the final handshake starts the next drain.
                        if (capture_i) begin
                            load = 1'b1;
                        end else begin
                            state_d = StIdle;
                        end
                    end else if (col_q != MAX_IDX) begin
                        col_d = col_q + 1'b1;
                    end else begin
                        col_d = '0;
                        row_d = row_q + 1'b1;
                    end
                end
                if (capture_i && !(out_ready_i && at_last)) begin
                    overrun_d = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= StIdle;
            row_q     <= '0;
            col_q     <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            row_q     <= row_d;
            col_q     <= col_d;
            overrun_q <= overrun_d;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < N * N; i++) begin
                buf_q[i] <= '0;
            end
        end else if (load) begin
            for (int i = 0; i < N * N; i++) begin
                buf_q[i] <= c_i[i*EW +: EW];
            end
        end
    end

    always_comb begin
        busy_o      = (state_q == StStream);
        out_valid_o = busy_o;
        out_data_o  = busy_o ? buf_q[idx] : '0;
        out_row_o   = busy_o ? row_q : '0;
        out_col_o   = busy_o ? col_q : '0;
        out_last_o  = busy_o && at_last;
        overrun_o   = overrun_q;
    end

endmodule

// File: tb/tb_result_drain.sv
// Directed bench for result_drain with N=2, DATA_WIDTH=8.
// Each comparison is an immediate assertion with a hand-computed expected value.
module tb_result_drain;

    localparam int unsigned N  = 2;
    localparam int unsigned DW = 8;
    localparam int unsigned EW = 2 * DW;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              capture_i;
    logic [N*N*EW-1:0] c_i;
    logic              busy_o;
    logic              out_valid_o;
    logic              out_ready_i;
    logic [EW-1:0]     out_data_o;
    logic [0:0]        out_row_o;
    logic [0:0]        out_col_o;
    logic              out_last_o;
    logic              overrun_o;

    int checks = 0;
    int errors = 0;

    result_drain #(.N(N), .DATA_WIDTH(DW)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .capture_i   (capture_i),
        .c_i         (c_i),
        .busy_o      (busy_o),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_data_o  (out_data_o),
        .out_row_o   (out_row_o),
        .out_col_o   (out_col_o),
        .out_last_o  (out_last_o),
        .overrun_o   (overrun_o)
    );

    always #5 clk = ~clk;

    function automatic logic [N*N*EW-1:0] pack4(input logic [15:0] e0, input logic [15:0] e1,
                                                input logic [15:0] e2, input logic [15:0] e3);
        return {e3, e2, e1, e0};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check({tag, " busy"}, 32'(busy_o), 0);
        check({tag, " valid"}, 32'(out_valid_o), 0);
        check({tag, " data"}, 32'(out_data_o), 0);
        check({tag, " row"}, 32'(out_row_o), 0);
        check({tag, " col"}, 32'(out_col_o), 0);
        check({tag, " last"}, 32'(out_last_o), 0);
    endtask

    task automatic check_elem(input string tag, input int k, input logic [15:0] d);
        check({tag, " valid"}, 32'(out_valid_o), 1);
        check({tag, " busy"}, 32'(busy_o), 1);
        check({tag, " data"}, 32'(out_data_o), 32'(d));
        check({tag, " row"}, 32'(out_row_o), 32'(k / 2));
        check({tag, " col"}, 32'(out_col_o), 32'(k % 2));
        check({tag, " last"}, 32'(out_last_o), 32'(k == 3));
    endtask

    logic [15:0] exp_d [4];
    logic        rdy_seq [7];
    int          e;

    initial begin
        reset_n     = 1'b0;
        capture_i   = 1'b0;
        c_i         = '0;
        out_ready_i = 1'b0;
        #12;
        check_idle("reset");
        check("reset overrun", 32'(overrun_o), 0);
        reset_n = 1'b1;
        tick();

        // Basic drain with c_i clobbered right after capture.
        c_i         = pack4(16'h0001, 16'h0002, 16'h0003, 16'h0004);
        capture_i   = 1'b1;
        out_ready_i = 1'b1;
        tick();
        capture_i = 1'b0;
        c_i       = {N*N*EW{1'b1}};
        for (int k = 0; k < 4; k++) begin
            check_elem("basic", k, 16'(k + 1));
            tick();
        end
        check_idle("basic done");

        // Backpressure with extreme values.
        exp_d   = '{16'hFFFF, 16'h0000, 16'h8001, 16'hFFFF};
        rdy_seq = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        c_i       = pack4(exp_d[0], exp_d[1], exp_d[2], exp_d[3]);
        capture_i = 1'b1;
        tick();
        capture_i = 1'b0;
        c_i       = '0;
        e         = 0;
        for (int i = 0; i < 7; i++) begin
            out_ready_i = rdy_seq[i];
            if (e < 4) check_elem("bp", e, exp_d[e]);
            tick();
            if (rdy_seq[i]) e++;
        end
        check_idle("bp done");

        // Back-to-back capture on the final handshake.
        out_ready_i = 1'b1;
        c_i         = pack4(16'd1, 16'd2, 16'd3, 16'd4);
        capture_i   = 1'b1;
        tick();
        capture_i = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (k == 3) begin
                capture_i = 1'b1;
                c_i       = pack4(16'd5, 16'd6, 16'd7, 16'd8);
            end
            check_elem("b2b", k % 4, 16'(k + 1));
            tick();
            capture_i = 1'b0;
            c_i       = '0;
        end
        check_idle("b2b done");
        check("b2b overrun", 32'(overrun_o), 0);

        // Overrun: capture while element 2 pending.
        c_i       = pack4(16'd1, 16'd2, 16'd3, 16'd4);
        capture_i = 1'b1;
        tick();
        capture_i = 1'b0;
        check_elem("ovr", 0, 16'd1);
        tick();
        capture_i = 1'b1;
        c_i       = pack4(16'hAAAA, 16'hBBBB, 16'hCCCC, 16'hDDDD);
        check_elem("ovr", 1, 16'd2);
        tick();
        capture_i = 1'b0;
        check("ovr flag", 32'(overrun_o), 1);
        check_elem("ovr", 2, 16'd3);
        tick();
        check_elem("ovr", 3, 16'd4);
        tick();
        check_idle("ovr done");
        check("ovr sticky", 32'(overrun_o), 1);
        tick();
        check("ovr sticky2", 32'(overrun_o), 1);

        // Reset mid-stream after two handshakes.
        c_i       = pack4(16'd1, 16'd2, 16'd3, 16'd4);
        capture_i = 1'b1;
        tick();
        capture_i = 1'b0;
        tick();
        tick();
        check_elem("pre-rst", 2, 16'd3);
        reset_n = 1'b0;
        #1;
        check_idle("mid rst");
        check("mid rst overrun", 32'(overrun_o), 0);
        tick();
        reset_n   = 1'b1;
        c_i       = pack4(16'd9, 16'd10, 16'd11, 16'd12);
        capture_i = 1'b1;
        tick();
        capture_i = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check_elem("post-rst", k, 16'(k + 9));
            tick();
        end
        check_idle("post-rst done");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/result_drain.md
# result_drain

Result collector for the systolic matrix multiplier. When the array of N×N MAC processing elements finishes a product, it snapshots every 2·DATA_WIDTH accumulator output in one cycle. It then streams the elements out in row-major order over a valid/ready interface, so the array can start the next operation immediately. It sits between the PE grid's accumulator outputs and the downstream result sink or memory writer.

## Interface
- N, default 4: array dimension; buffer holds N·N elements; N ≥ 2.
- DATA_WIDTH, default 8: PE operand width; result element width is 2·DATA_WIDTH.
- IW (local): max(1, $clog2(N)), the row/column index width.
- clk  input  1  clock, all state updates on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- capture_i  input  1  single-cycle pulse: array accumulators are final, snapshot them.
- c_i  input  N·N·2·DATA_WIDTH  flattened accumulator outputs; element (r,c) at bits [(r·N+c)·2·DATA_WIDTH +: 2·DATA_WIDTH].
- busy_o  output  1  snapshot held and not yet fully drained.
- out_valid_o  output  1  out_data_o holds a valid element.
- out_ready_i  input  1  sink accepts the element this cycle.
- out_data_o  output  2·DATA_WIDTH  current element.
- out_row_o  output  IW  row index of current element.
- out_col_o  output  IW  column index of current element.
- out_last_o  output  1  current element is (N-1,N-1).
- overrun_o  output  1  sticky flag: a capture was dropped while busy.

## Operation
- Storage: N·N registers of 2·DATA_WIDTH bits, plus row and column counters, a 2-state FSM, and the overrun flag.
- FSM states: IDLE and STREAM.
- IDLE, capture_i=1:
  - load all N·N elements from c_i into the buffer;
  - set row=0, col=0;
  - go to STREAM.
- IDLE, capture_i=0: hold.
- STREAM, handshake (out_valid_o & out_ready_i):
  - col<N-1: col++.
  - col=N-1, row<N-1: col=0, row++.
  - at (N-1,N-1): go to IDLE.
- STREAM, no handshake: row, col and out_data_o are held stable. Valid must not drop and data must not change while ready is low.
- Outputs in STREAM:
  - out_valid_o=1;
  - out_data_o=buffer[row·N+col];
  - out_row_o=row, out_col_o=col;
  - out_last_o=(row==N-1 && col==N-1).
- Outputs in IDLE: out_valid_o=0, out_last_o=0. out_data_o, out_row_o and out_col_o read 0.
- busy_o = (state==STREAM).
- Back-to-back: capture_i in the same cycle as the final handshake is accepted. The buffer reloads, row and col return to 0, and the FSM stays in STREAM.
- Capture in STREAM on any other cycle: ignored, buffer unchanged, overrun_o set to 1. overrun_o is cleared only by reset.
- Data is passed through unmodified: no truncation, sign or width change.

## Timing
- Reset values: state=IDLE, buffer=0, row=col=0, busy_o=0, out_valid_o=0, out_data_o=0, out_row_o=0, out_col_o=0, out_last_o=0, overrun_o=0.
- Reset asserted mid-stream aborts immediately (asynchronous). All outputs take their reset values and the remaining elements are discarded.
- Latency: capture_i high at edge t → out_valid_o=1 with element (0,0) after edge t.
- c_i is sampled only at the capturing edge. It may change from the next cycle on, since the array is free to clear and accumulate again.
- Throughput: one element per cycle with out_ready_i held high. A full drain takes N·N cycles, and busy_o falls after the edge of the last handshake.
- out_valid_o does not depend combinationally on out_ready_i.

## Test plan
- N=2, DW=8. Reset, then capture with c_i elements {0x0001,0x0002,0x0003,0x0004} and ready=1 → next 4 cycles:
  - data 1,2,3,4;
  - (row,col)=(0,0),(0,1),(1,0),(1,1);
  - last only on the 4th;
  - busy_o low on the 5th cycle.
- Backpressure: ready toggled 1,0,0,1,1,0,1 → each element stays stable while ready=0; exactly 4 handshakes in order; no duplicates or skips.
- Snapshot isolation: change c_i to all 0xFFFF one cycle after capture → the stream still outputs 1,2,3,4. Extremes 0xFFFF/0x0000 pass through unchanged.
- Back-to-back: second capture with {5,6,7,8} coincident with the handshake of element 4 → stream 1..8 continuous, out_valid_o never drops, overrun_o=0.
- Overrun: capture while element 2 is pending → the stream continues 2,3,4 unchanged and overrun_o=1 until reset.
- Reset mid-stream after 2 handshakes → all outputs 0 immediately. A following capture of {9,10,11,12} streams from (0,0).
